// File: rtl/lambda_sub_pipe_pkg.sv
// -----------------------------------------------------------------------------
// data_type: shared definitions for the lambda subtractor pipeline.
// Holds the default fixed-point widths (Q6.8 mag/phi/lambda, Q1.7 rho), the
// value rho takes at reset, the matching scalar types and a small constant
// helper used to size internal datapath widths.
// -----------------------------------------------------------------------------
package data_type;

  localparam int MAG_W    = 14;  // signed Q6.8
  localparam int PHI_W    = 14;  // unsigned Q6.8
  localparam int RHO_W    = 8;   // signed Q1.7
  localparam int RHO_FRAC = 7;
  localparam int LAMBDA_W = 14;  // signed Q6.8

  localparam logic signed [RHO_W-1:0] RHO_DEFAULT = 8'sh7F;  // 0.9921875

  typedef logic signed [MAG_W-1:0]    mag_t;
  typedef logic        [PHI_W-1:0]    phi_t;
  typedef logic signed [RHO_W-1:0]    rho_t;
  typedef logic signed [LAMBDA_W-1:0] lambda_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lambda_sub_lane.sv
// -----------------------------------------------------------------------------
// lambda_sub_lane: one channel of the lambda = mag - rho*phi datapath.
//   S1: prod  = rho * {0,phi}                (full signed width)
//   S2: sh    = prod >>> RHO_FRAC (floor), mag sign-extended by 2 bits
//   S3: diff  = mag - sh at full width, reduced to LAMBDA_W and registered
// Reduction: clamp (LAMBDA_SAT_EN defined) or two's-complement wrap (default).
//
// Ports:
//   clk, rst      clock / synchronous active-low reset
//   s1_en_i       load S1 (a beat is accepted)
//   s2_en_i       load S2 (S1 holds a beat and S2 may advance)
//   s3_en_i       load S3 (S2 holds a beat and the output may advance)
//   mag_i, phi_i  channel inputs; rho_i rho applied to this beat
//   lambda_o      registered lambda; sat_o registered clamp indicator
// -----------------------------------------------------------------------------
module lambda_sub_lane #(
  parameter int MAG_W    = data_type::MAG_W,
  parameter int PHI_W    = data_type::PHI_W,
  parameter int RHO_W    = data_type::RHO_W,
  parameter int RHO_FRAC = data_type::RHO_FRAC,
  parameter int LAMBDA_W = data_type::LAMBDA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s1_en_i,
  input  logic                s2_en_i,
  input  logic                s3_en_i,
  input  logic [MAG_W-1:0]    mag_i,
  input  logic [PHI_W-1:0]    phi_i,
  input  logic [RHO_W-1:0]    rho_i,
  output logic [LAMBDA_W-1:0] lambda_o,
  output logic                sat_o
);

  localparam int PROD_W = RHO_W + PHI_W + 1;
  localparam int SH_W   = PROD_W - RHO_FRAC;
  localparam int MAGX_W = MAG_W + 2;
  localparam int DIFF_W = data_type::max_int(MAGX_W, SH_W) + 1;

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [MAG_W-1:0]  mag1_q;
  logic signed [MAGX_W-1:0] mag2_q;
  logic signed [SH_W-1:0]   sh2_q;
  logic signed [DIFF_W-1:0] mag_x, sh_x, diff;
  logic [LAMBDA_W-1:0]      lambda_d, lambda_q;
  logic                     sat_d;

  // phi is unsigned: a zero MSB makes it a non-negative signed operand.
  assign prod_d = PROD_W'($signed(rho_i)) * PROD_W'($signed({1'b0, phi_i}));

  // NOTE: interior stage data carries no reset; the stage valid bits held in
  // the top qualify it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (s1_en_i) begin
      prod_q <= prod_d;
      mag1_q <= mag_i;
    end
    if (s2_en_i) begin
      mag2_q <= MAGX_W'(mag1_q);
      // Dropping the low RHO_FRAC bits of a two's-complement value floors it.
      sh2_q  <= prod_q[PROD_W-1:RHO_FRAC];
    end
  end

  assign mag_x = DIFF_W'(mag2_q);
  assign sh_x  = DIFF_W'(sh2_q);
  assign diff  = mag_x - sh_x;

`ifdef LAMBDA_SAT_EN
  localparam logic signed [DIFF_W-1:0] LAM_MAX =
    {{(DIFF_W-LAMBDA_W+1){1'b0}}, {(LAMBDA_W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] LAM_MIN = ~LAM_MAX;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    lambda_d = diff[LAMBDA_W-1:0];
    sat_d    = 1'b0;
    if (diff > LAM_MAX) begin
      lambda_d = LAM_MAX[LAMBDA_W-1:0];
      sat_d    = 1'b1;
    end else if (diff < LAM_MIN) begin
      lambda_d = LAM_MIN[LAMBDA_W-1:0];
      sat_d    = 1'b1;
    end
  end
`else
  // Legacy wrap: only the low LAMBDA_W bits survive.
  logic unused_diff_hi;
  assign unused_diff_hi = ^diff[DIFF_W-1:LAMBDA_W];
  assign lambda_d       = diff[LAMBDA_W-1:0];
  assign sat_d          = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lambda_q <= '0;
    end else if (s3_en_i) begin
      lambda_q <= lambda_d;
    end
  end
  assign lambda_o = lambda_q;

`ifdef LAMBDA_SAT_EN
  logic sat_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else if (s3_en_i) begin
      sat_q <= sat_d;
    end
  end
  assign sat_o = sat_q;
`else
  assign sat_o = sat_d;
`endif

endmodule

// File: rtl/lambda_sub_pipe.sv
// -----------------------------------------------------------------------------
// lambda_sub_pipe: NCH-channel lambda = mag - rho*phi, 3-stage valid/ready
// pipeline with backpressure and a frame-synchronous programmable rho.
// Optional feature macro: LAMBDA_SAT_EN (clamp + sat_flag/sat_count);
// undefined gives the legacy two's-complement wrap with sat outputs tied 0.
//
// Ports:
//   clk, rst                  clock / synchronous active-low reset
//   in_valid/in_ready         input handshake; in_ready chains from out_ready
//   in_mag, in_phi, in_last   per-channel inputs, frame-end sideband
//   rho_wr_en, rho_wr_data    rho shadow write
//   out_valid/out_ready       output handshake
//   out_lambda, out_last      per-channel result, frame-end sideband
//   sat_flag, sat_count       per-channel clamp flag, saturating beat count
// -----------------------------------------------------------------------------
module lambda_sub_pipe #(
  parameter int NCH      = 4,
  parameter int MAG_W    = data_type::MAG_W,
  parameter int PHI_W    = data_type::PHI_W,
  parameter int RHO_W    = data_type::RHO_W,
  parameter int RHO_FRAC = data_type::RHO_FRAC,
  parameter int LAMBDA_W = data_type::LAMBDA_W,
  parameter logic [RHO_W-1:0] RHO_RESET = data_type::RHO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*MAG_W-1:0]    in_mag,
  input  logic [NCH*PHI_W-1:0]    in_phi,
  input  logic                    in_last,
  input  logic                    rho_wr_en,
  input  logic [RHO_W-1:0]        rho_wr_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*LAMBDA_W-1:0] out_lambda,
  output logic                    out_last,
  output logic [NCH-1:0]          sat_flag,
  output logic [15:0]             sat_count
);

  // ---------------------------------------------------------------- control
  logic s1_v_q, s2_v_q, s3_v_q;
  logic last1_q, last2_q, last3_q;
  logic s1_en, s2_en, s3_en;
  logic accept, s2_load, s3_load;

  // A stage may capture when it is empty or its contents move on this cycle.
  assign s3_en    = !s3_v_q || out_ready;
  assign s2_en    = !s2_v_q || s3_en;
  assign s1_en    = !s1_v_q || s2_en;
  assign in_ready = s1_en;

  assign accept  = in_valid && in_ready;
  assign s2_load = s2_en && s1_v_q;
  assign s3_load = s3_en && s2_v_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s3_v_q  <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
    end else begin
      if (s1_en) s1_v_q <= in_valid;
      if (s2_en) s2_v_q <= s1_v_q;
      if (s3_en) s3_v_q <= s2_v_q;
      if (accept)  last1_q <= in_last;
      if (s2_load) last2_q <= last1_q;
      if (s3_load) last3_q <= last2_q;
    end
  end

  assign out_valid = s3_v_q;
  assign out_last  = last3_q;

  // -------------------------------------------------------------------- rho
  logic [RHO_W-1:0] shadow_q, shadow_d, rho_act_q, rho_act_d;
  logic             pending_q, pending_d, in_frame_q, in_frame_d;
  logic             apply;

  // Frame boundary: the accept of a last beat, or an idle cycle between frames.
  assign apply = (accept && in_last) || (!in_frame_q && !accept);

  always_comb begin
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    rho_act_d  = rho_act_q;
    in_frame_d = in_frame_q;
    if (accept) in_frame_d = !in_last;
    if (rho_wr_en) begin
      shadow_d  = rho_wr_data;
      pending_d = 1'b1;
    end
    if (apply && (pending_q || rho_wr_en)) begin
      // A write coinciding with the boundary bypasses the shadow.
      rho_act_d = rho_wr_en ? rho_wr_data : shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q   <= RHO_RESET;
      rho_act_q  <= RHO_RESET;
      pending_q  <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      rho_act_q  <= rho_act_d;
      pending_q  <= pending_d;
      in_frame_q <= in_frame_d;
    end
  end

  // ------------------------------------------------------------------ lanes
  logic [NCH-1:0] lane_sat;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    lambda_sub_lane #(
      .MAG_W    (MAG_W),
      .PHI_W    (PHI_W),
      .RHO_W    (RHO_W),
      .RHO_FRAC (RHO_FRAC),
      .LAMBDA_W (LAMBDA_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .s1_en_i  (accept),
      .s2_en_i  (s2_load),
      .s3_en_i  (s3_load),
      .mag_i    (in_mag[c*MAG_W +: MAG_W]),
      .phi_i    (in_phi[c*PHI_W +: PHI_W]),
      .rho_i    (rho_act_q),
      .lambda_o (out_lambda[c*LAMBDA_W +: LAMBDA_W]),
      .sat_o    (lane_sat[c])
    );
  end

  assign sat_flag = lane_sat;

  // ---------------------------------------------------------- sat counter
`ifdef LAMBDA_SAT_EN
  logic [15:0] sat_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_cnt_q <= '0;
    end else if (out_valid && out_ready && (|lane_sat) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end
  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: doc/lambda_sub_pipe.md
# lambda_sub_pipe

Parametrised, multi-channel successor to the single-channel fixed-rho lambda subtractor. Computes lambda = mag − rho·phi per channel in fixed point. Adds a valid/ready pipeline with backpressure and a runtime-programmable rho that changes only at frame boundaries, and offers optional output saturation. It sits between the magnitude/phase front end and the lambda consumer (LLR/decision stage).

## Interface
Parameters:
- NCH, 4, number of parallel channels per beat
- MAG_W, 14, signed mag width (Q6.8)
- PHI_W, 14, unsigned phi width (Q6.8)
- RHO_W, 8, signed rho width (Q1.7)
- RHO_FRAC, 7, rho fractional bits
- LAMBDA_W, 14, signed lambda width (Q6.8)
- RHO_RESET, 8'sh7F, rho value loaded at reset (0.9921875)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset; synchronous, active-low (rst == 0 resets)
- in_valid  in  1  input beat valid
- in_ready  out  1  stage accepts a beat this cycle
- in_mag  in  NCH×MAG_W  per-channel mag, signed
- in_phi  in  NCH×PHI_W  per-channel phi, unsigned
- in_last  in  1  last beat of frame
- rho_wr_en  in  1  write rho shadow register
- rho_wr_data  in  RHO_W  new rho, signed
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_lambda  out  NCH×LAMBDA_W  per-channel lambda, signed
- out_last  out  1  in_last carried through the pipeline
- sat_flag  out  NCH  per-channel clamp indicator (saturation build only)
- sat_count  out  16  saturating count of beats with any sat_flag set

## Operation
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Pipeline has 3 registered stages, each with its own valid bit.
  - S1: prod = rho_active × {1'b0, phi}, width RHO_W+PHI_W+1, signed.
  - S2: prod >>> RHO_FRAC (arithmetic, floor toward −∞); sign-extend mag to MAG_W+2 bits.
  - S3: diff = mag − shifted prod, computed at full width. The result is then reduced to LAMBDA_W by the configured rule and registered as out_lambda.
- Each stage captures when it is empty or the next stage advances. in_ready = !S1_valid || S1 advances. The output holds stable while out_valid && !out_ready.
- The in_last sideband, and the rho value used for a beat, travel with that beat.
- Rho programming:
  - rho_wr_en loads the shadow register and sets `pending`. A later write overwrites the shadow.
  - in_frame is set by an accepted non-last beat and cleared by an accepted last beat.
  - rho_active ← shadow, and pending clears, in either of these cycles:
    - a cycle accepting a beat with in_last (the new value applies from the next beat);
    - a cycle with !in_frame and no accept.
  - If rho_wr_en and the apply condition occur in the same cycle, the new rho_wr_data is applied directly.
- sat_count increments on each emitted beat with any sat_flag set. It sticks at 0xFFFF.

## Timing
- Latency: 3 cycles from accept to out_valid with no stall. Throughput is 1 beat/cycle.
- Reset (rst == 0 at posedge) sets:
  - all stage valids 0, out_valid 0, out_lambda 0, out_last 0;
  - sat_flag 0, sat_count 0, rho_active and shadow = RHO_RESET, pending 0, in_frame 0.
- in_ready is 1 in the first cycle after reset. Reset mid-operation discards all in-flight beats. No partial output is emitted.
- in_ready depends combinationally on out_ready (ready chain through the 3 stages). No combinational path exists from in_valid to out_valid.

## Configuration
- LAMBDA_SAT_EN defined: diff is clamped to [−2^(LAMBDA_W−1), 2^(LAMBDA_W−1)−1]. sat_flag[c] is 1 when channel c clamped, and sat_count is active.
- LAMBDA_SAT_EN undefined: diff is truncated to its low LAMBDA_W bits (two's-complement wrap, the legacy behaviour). sat_flag and sat_count are constant 0 and their logic is removed.

## Structure
- Shared package data_type holds mag_t, phi_t, rho_t, lambda_t, the *_W and RHO_FRAC constants, and RHO_DEFAULT (8'sh7F).
- One sub-module, lambda_sub_lane: the per-channel multiply/shift/subtract/saturate datapath, instantiated NCH times.
- Valid/ready control, the rho logic and the counter live in the top module.

## Test plan
- Basic result: rho 0x7F, phi 0x0100, mag 0x0200 on all channels. Expect out_lambda 0x0102 (258) exactly 3 cycles after accept.
- Negative rho and floor:
  - rho 0x80, phi 0x0100, mag 0 → 0x0100.
  - rho 0xFF, phi 0x0001, mag 0 → 0x0001.
  - rho 0x01, phi 0x0001, mag 0 → 0x0000.
- Overflow: mag 0x2000 (−8192), phi 0x3FFF, rho 0x7F.
  - With LAMBDA_SAT_EN: lambda 0x2000, sat_flag set, sat_count 1.
  - Without it: lambda 0x2081 (−8063).
- Backpressure: stream 10 beats with distinct values while out_ready toggles 1,0,0,1. Expect no loss, no duplication, order preserved, and outputs stable while stalled.
- Rho at frame boundary: write rho 0x40 mid-frame. Expect the remaining beats of that frame to use 0x7F and the first beat of the next frame to use 0x40. With no frame open, the write applies on the next cycle.
- Reset mid-stream: assert rst == 0 with 3 beats in flight. Expect out_valid 0, sat_count 0 and rho 0x7F on the next cycle, and no stale beat emitted afterwards.
